// File: rtl/fp_operand_unpacker_pkg.sv
// Shared definitions for the floating-point operand unpacker: class codes,
// default field widths and packed-operand field positions.
package fp_operand_unpacker_pkg;

    localparam int unsigned EXP_W_DEF  = 5;
    localparam int unsigned FRAC_W_DEF = 5;
    localparam int          BIAS_DEF   = 15;

    // Fraction occupies the low bits of a packed operand {sign, exp, frac}.
    localparam int unsigned FRAC_LSB = 0;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } fp_class_e;

    function automatic int unsigned sign_pos(input int unsigned exp_w,
                                             input int unsigned frac_w);
        return exp_w + frac_w;
    endfunction

    function automatic int unsigned exp_lsb(input int unsigned frac_w);
        return FRAC_LSB + frac_w;
    endfunction

    // Product class: NaN dominates (inf x zero is also NaN), then inf, then zero.
    function automatic fp_class_e combine_class(input fp_class_e cls_a,
                                                input fp_class_e cls_b);
        fp_class_e res;
        res = CLS_NORM;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            res = CLS_NAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            res = CLS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            res = CLS_ZERO;
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational decode of one packed operand into class, sign, exponent and
// mantissa with the hidden bit restored (mantissa is zero for non-normals).
module fp_class_decode
    import fp_operand_unpacker_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic [EXP_W+FRAC_W:0] op,
    output fp_class_e             cls,
    output logic                  sign,
    output logic [EXP_W-1:0]      exp_f,
    output logic [FRAC_W:0]       mant
);

    localparam int unsigned SignPos = sign_pos(EXP_W, FRAC_W);
    localparam int unsigned ExpLsb  = exp_lsb(FRAC_W);

    logic [FRAC_W-1:0] frac;

    assign sign  = op[SignPos];
    assign exp_f = op[ExpLsb +: EXP_W];
    assign frac  = op[FRAC_LSB +: FRAC_W];

    // Subnormals flush to zero: a zero exponent ignores the fraction.
    always_comb begin
        cls = CLS_NORM;
        if (exp_f == '0) begin
            cls = CLS_ZERO;
        end else if (&exp_f) begin
            cls = (frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

    assign mant = (cls == CLS_NORM) ? {1'b1, frac} : '0;

endmodule

// File: rtl/fp_operand_unpacker.sv
// Two-stage stallable front end: S1 captures and classifies operands, S2 holds
// the combined class, product sign, biased exponent sum and masked mantissas.
module fp_operand_unpacker
    import fp_operand_unpacker_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int          BIAS   = BIAS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     op_a,
    input  logic [EXP_W+FRAC_W:0]     op_b,
    input  logic [2:0]                prec_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAC_W:0]           mA,
    output logic [FRAC_W:0]           mB,
    output logic [2:0]                SEL,
    output logic                      sign_c,
    output logic signed [EXP_W+1:0]   exp_c,
    output logic [1:0]                special
);

    localparam int unsigned OpW   = EXP_W + FRAC_W + 1;
    localparam logic [EXP_W+1:0] BiasW = BIAS[EXP_W+1:0];

    // Stage 1 state
    logic           s1_valid_q;
    logic [OpW-1:0] s1_op_a_q;
    logic [OpW-1:0] s1_op_b_q;
    logic [2:0]     s1_sel_q;

    // Stage 2 state
    logic                  s2_valid_q;
    logic [FRAC_W:0]       s2_ma_q;
    logic [FRAC_W:0]       s2_mb_q;
    logic [2:0]            s2_sel_q;
    logic                  s2_sign_q;
    logic [EXP_W+1:0]      s2_exp_q;
    logic [1:0]            s2_cls_q;

    logic s1_load;
    logic s2_adv;

    fp_class_e        cls_a, cls_b, cls_c;
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [FRAC_W:0]  mant_a, mant_b;

    logic [FRAC_W:0]  ma_d, mb_d;
    logic [EXP_W+1:0] exp_d;

    // Handshake: in_ready depends on out_ready but never on in_valid.
    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign s1_load  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_a_q  <= '0;
            s1_op_b_q  <= '0;
            s1_sel_q   <= '0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_op_a_q  <= op_a;
            s1_op_b_q  <= op_b;
            s1_sel_q   <= prec_sel;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    fp_class_decode #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_dec_a (
        .op    (s1_op_a_q),
        .cls   (cls_a),
        .sign  (sign_a),
        .exp_f (exp_a),
        .mant  (mant_a)
    );

    fp_class_decode #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_dec_b (
        .op    (s1_op_b_q),
        .cls   (cls_b),
        .sign  (sign_b),
        .exp_f (exp_b),
        .mant  (mant_b)
    );

    // Exponent sum wraps in EXP_W+2 bits; rounding downstream handles range.
    always_comb begin
        cls_c = combine_class(cls_a, cls_b);
        ma_d  = '0;
        mb_d  = '0;
        exp_d = '0;
        if (cls_c == CLS_NORM) begin
            ma_d  = mant_a;
            mb_d  = mant_b;
            exp_d = {2'b00, exp_a} + {2'b00, exp_b} - BiasW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_ma_q    <= '0;
            s2_mb_q    <= '0;
            s2_sel_q   <= '0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_cls_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= 1'b1;
            s2_ma_q    <= ma_d;
            s2_mb_q    <= mb_d;
            s2_sel_q   <= s1_sel_q;
            s2_sign_q  <= sign_a ^ sign_b;
            s2_exp_q   <= exp_d;
            s2_cls_q   <= cls_c;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign mA        = s2_ma_q;
    assign mB        = s2_mb_q;
    assign SEL       = s2_sel_q;
    assign sign_c    = s2_sign_q;
    assign exp_c     = s2_exp_q;
    assign special   = s2_cls_q;

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// Scoreboard bench for fp_operand_unpacker: expected results are queued on
// accept and compared in order when the DUT hands a result out.
module tb_fp_operand_unpacker;

    typedef struct packed {
        logic [5:0] ma;
        logic [5:0] mb;
        logic [2:0] sel;
        logic       sgn;
        logic [6:0] expc;
        logic [1:0] spec;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] op_a;
    logic [10:0] op_b;
    logic [2:0]  prec_sel;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  mA;
    logic [5:0]  mB;
    logic [2:0]  SEL;
    logic        sign_c;
    logic [6:0]  exp_c;
    logic [1:0]  special;

    res_t obs;
    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    assign obs = {mA, mB, SEL, sign_c, exp_c, special};

    always #5 clk = ~clk;

    fp_operand_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .prec_sel  (prec_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mA        (mA),
        .mB        (mB),
        .SEL       (SEL),
        .sign_c    (sign_c),
        .exp_c     (exp_c),
        .special   (special)
    );

    // Reference model: 0 norm, 1 zero, 2 inf, 3 NaN per operand.
    function automatic int op_class(input logic [10:0] op);
        int e, f;
        e = int'(op[9:5]);
        f = int'(op[4:0]);
        if (e == 0) return 1;
        if (e == 31) return (f == 0) ? 2 : 3;
        return 0;
    endfunction

    function automatic res_t model(input logic [10:0] a, input logic [10:0] b,
                                   input logic [2:0] sel);
        res_t r;
        int ca, cb, sp;
        ca = op_class(a);
        cb = op_class(b);
        if (ca == 3 || cb == 3 || (ca == 2 && cb == 1) || (ca == 1 && cb == 2)) sp = 3;
        else if (ca == 2 || cb == 2) sp = 2;
        else if (ca == 1 || cb == 1) sp = 1;
        else sp = 0;
        r      = '0;
        r.sel  = sel;
        r.sgn  = a[10] ^ b[10];
        r.spec = 2'(sp);
        if (sp == 0) begin
            r.ma   = 6'(32 + int'(a[4:0]));
            r.mb   = 6'(32 + int'(b[4:0]));
            r.expc = 7'(int'(a[9:5]) + int'(b[9:5]) - 15);
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        prec_sel  = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_fields: got %h want 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_normal();
        int   acc_c = -1;
        int   got_c = -1;
        res_t e;
        for (int c = 0; c < 12 && got_c < 0; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (acc_c < 0);
            op_a      = 11'h1F0;
            op_b      = 11'h200;
            prec_sel  = 3'd3;
            #4;
            if (in_valid && in_ready) begin
                acc_c = c;
                exp_q.push_back(model(op_a, op_b, prec_sel));
            end
            if (out_valid && out_ready) begin
                got_c = c;
                e = exp_q.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL normal_fields: got %h want %h", obs, e);
                end
                total++;
                if (mA !== 6'h30 || mB !== 6'h20 || exp_c !== 7'd16 || SEL !== 3'd3 ||
                    special !== 2'b00 || sign_c !== 1'b0) begin
                    bad++;
                    $display("FAIL normal_const: got mA=%h mB=%h exp=%0d sel=%0d sp=%b s=%b",
                             mA, mB, exp_c, SEL, special, sign_c);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc_c < 0 || got_c - acc_c != 2) begin
            bad++;
            $display("FAIL normal_latency: got %0d cycles want 2 (acc=%0d out=%0d)",
                     got_c - acc_c, acc_c, got_c);
        end
    endtask

    task automatic test_special();
        logic [10:0] pa [4] = '{11'h000, 11'h3E0, 11'h3E0, 11'h020};
        logic [10:0] pb [4] = '{11'h5F0, 11'h000, 11'h1F0, 11'h020};
        logic [1:0]  sp [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int   idx = 0;
        int   got = 0;
        res_t e;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 4);
            if (idx < 4) begin
                op_a     = pa[idx];
                op_b     = pb[idx];
                prec_sel = 3'(idx + 1);
            end
            #4;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op_a, op_b, prec_sel));
                idx++;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL special_fields[%0d]: got %h want %h", got, obs, e);
                end
                total++;
                if (special !== sp[got]) begin
                    bad++;
                    $display("FAIL special_class[%0d]: got %b want %b", got, special, sp[got]);
                end
                if (got == 0) begin
                    total++;
                    if (sign_c !== 1'b1 || mA !== 6'h0 || mB !== 6'h0 || exp_c !== 7'h0) begin
                        bad++;
                        $display("FAIL special_zero: got s=%b mA=%h mB=%h exp=%h want 1/0/0/0",
                                 sign_c, mA, mB, exp_c);
                    end
                end
                if (got == 3) begin
                    total++;
                    if (exp_c !== 7'b1110011) begin
                        bad++;
                        $display("FAIL underflow_exp: got %b want 1110011", exp_c);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL special_count: got %0d want 4", got);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] pa [3] = '{11'h1F0, 11'h2A5, 11'h433};
        logic [10:0] pb [3] = '{11'h200, 11'h1C7, 11'h0E1};
        int   idx = 0;
        int   got = 0;
        res_t held;
        res_t e;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (idx < 3);
            if (idx < 3) begin
                op_a     = pa[idx];
                op_b     = pb[idx];
                prec_sel = 3'(idx + 5);
            end
            #4;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op_a, op_b, prec_sel));
                idx++;
            end
            if (c == 2) held = obs;
            if (c >= 2) begin
                total++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    bad++;
                    $display("FAIL stall_stable[%0d]: got v=%b %h want v=1 %h",
                             c, out_valid, obs, held);
                end
            end
        end
        total++;
        if (idx != 2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_accept: got %0d accepted in_ready=%b want 2 and 0",
                     idx, in_ready);
        end
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 3);
            if (idx < 3) begin
                op_a     = pa[idx];
                op_b     = pb[idx];
                prec_sel = 3'(idx + 5);
            end
            #4;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op_a, op_b, prec_sel));
                idx++;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL drain_order[%0d]: got %h want %h", got, obs, e);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        #4;
        total++;
        if (got != 3 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_count: got %0d v=%b left=%0d want 3 0 0",
                     got, out_valid, exp_q.size());
        end
    endtask

    task automatic test_stream();
        int   idx = 0;
        int   got = 0;
        int   first_c = -1;
        int   last_c = -1;
        res_t e;
        for (int c = 0; c < 30 && got < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 8);
            op_a      = 11'($urandom);
            op_b      = 11'($urandom);
            prec_sel  = 3'(idx);
            #4;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op_a, op_b, prec_sel));
                idx++;
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL stream[%0d]: got %h want %h", got, obs, e);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (got != 8 || last_c - first_c != 7) begin
            bad++;
            $display("FAIL stream_rate: got %0d results over %0d cycles want 8 over 8",
                     got, last_c - first_c + 1);
        end
    endtask

    task automatic test_back_to_back();
        int   idx = 0;
        int   got = 0;
        res_t e;
        for (int c = 0; c < 300 && got < 20; c++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (idx < 20) && ($urandom_range(0, 3) != 0);
            op_a      = 11'($urandom);
            op_b      = 11'($urandom);
            prec_sel  = 3'($urandom);
            #4;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op_a, op_b, prec_sel));
                idx++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL random_extra: got %h want none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL random[%0d]: got %h want %h", got, obs, e);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (got != 20) begin
            bad++;
            $display("FAIL random_count: got %0d want 20", got);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            op_a      = 11'h1F0 + 11'(c);
            op_b      = 11'h200;
            prec_sel  = 3'(c + 2);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_inflight: got v=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            bad++;
            $display("FAIL mid_reset_async: got v=%b %h want 0 0", out_valid, obs);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_in_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #4;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale[%0d]: got v=%b %h want 0", c, out_valid, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_stream();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_operand_unpacker.md
Name: fp_operand_unpacker

Overview:
- Front end that feeds the mantissa error-correction multiplier datapath.
- Accepts two packed floating-point operands plus a precision code over a valid/ready handshake, and classifies both operands.
- Extracts 6-bit mantissas with the hidden bit restored and forms the product sign and biased exponent sum.
- Delivers mA/mB/SEL and side-band fields through a 2-stage stallable pipeline, so operands and results stay aligned.

Parameters:
- EXP_W, 5, exponent field width.
- FRAC_W, 5, stored fraction width; mantissa width is FRAC_W+1 = 6 and is fixed by the downstream mantissa ports.
- BIAS, 15, exponent bias subtracted once from the exponent sum.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- op_a  in  1+EXP_W+FRAC_W  packed operand {sign, exp, frac}.
- op_b  in  1+EXP_W+FRAC_W  packed operand {sign, exp, frac}.
- prec_sel  in  3  precision code, captured together with the operands.
- out_valid  out  1  result fields valid.
- out_ready  in  1  downstream accepts the result.
- mA  out  6  {hidden, frac} of op_a; 0 unless class is normal.
- mB  out  6  {hidden, frac} of op_b; 0 unless class is normal.
- SEL  out  3  prec_sel that travelled with this pair, passed unchanged.
- sign_c  out  1  sign_a XOR sign_b.
- exp_c  out  EXP_W+2  signed, eA + eB - BIAS; 0 unless class is normal.
- special  out  2  00 normal, 01 zero, 10 inf, 11 NaN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both stage valid bits clear immediately, so out_valid=0.
  - mA, mB, SEL, sign_c, exp_c and special all reset to 0.
  - in_ready=1 on the first edge after reset release.
  - A transaction in flight when reset asserts is dropped without any output.
- Pipeline structure:
  - S1 registers op_a, op_b and prec_sel, and decodes each operand's class.
  - S2 registers the combined class, sign, exponent sum and masked mantissas; the S2 registers drive the outputs directly.
- Handshake:
  - Transfer in occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv. in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - Latency is 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 pair per cycle.
  - With out_ready held low, the block holds 2 pairs, then in_ready=0.
  - Output fields stay stable while out_valid & !out_ready.
  - Order is always preserved. Simultaneous accept and drain in the same cycle loses no data.
- Per-operand class:
  - exp==0 gives zero (flush-to-zero: subnormals are treated as zero, frac ignored).
  - exp all-ones with frac==0 gives inf.
  - exp all-ones with frac!=0 gives NaN.
  - Otherwise the operand is normal.
- Combined class, in priority order:
  - Any NaN, or inf×zero, gives NaN.
  - Otherwise any inf gives inf.
  - Otherwise any zero gives zero.
  - Otherwise normal.
- Arithmetic and width rules:
  - exp_c is computed in EXP_W+2 signed width with no saturation; underflow and overflow go to downstream rounding.
  - sign_c is valid for every class.

Decomposition:
- Shared package holds:
  - Class encoding constants: CLS_NORM=2'b00, CLS_ZERO=2'b01, CLS_INF=2'b10, CLS_NAN=2'b11.
  - Defaults for EXP_W, FRAC_W and BIAS.
  - The packed-operand field positions.
- One sub-module, fp_class_decode: purely combinational, maps a single operand to {class, sign, exp, mantissa}. It is instantiated twice in S1.

Test Plan:
- Normal product: op_a=0x1F0 (+1.5), op_b=0x200 (+2.0), prec_sel=3, out_ready=1.
  - Expect out_valid exactly 2 cycles after accept.
  - mA=0x30, mB=0x20, exp_c=16, sign_c=0, special=00, SEL=3.
- Special operands:
  - op_a=0x000, op_b=0x5F0 → special=01, mA=mB=0, exp_c=0, sign_c=1.
  - op_a=0x3E0, op_b=0x000 → special=11 (inf×zero).
  - op_a=0x3E0, op_b=0x1F0 → special=10.
- Exponent underflow: op_a=op_b=0x020 (exp=1) → exp_c = 1+1-15 = -13 in signed EXP_W+2 width (7'b1110011 at defaults), special=00.
- Backpressure: hold out_ready=0 and offer 3 back-to-back pairs.
  - Expect the first 2 accepted, then in_ready=0 with outputs stable.
  - Then raise out_ready: all 3 emerge in order with no duplicates or loss.
- Streaming: 8 consecutive pairs with out_ready=1 throughout → one result per cycle, with SEL matching each pair's prec_sel.
- Reset mid-operation: assert rst_n=0 while 2 pairs are in flight.
  - Expect out_valid=0 and all outputs 0 without waiting for a clock edge.
  - After release, in_ready=1 and no stale result ever appears.
